// File: rtl/synth_pkg.sv
// Shared widths and the control-word split for the PWM voice synthesiser.
// PWM_VOLUME_EN selects a 4-bit volume in W[15:12] with a 12-bit period below it.
package synth_pkg;
    localparam int NUM_VOICES = 8;
    localparam int VOL_W      = 4;
    localparam int MIX_W      = 7;
    localparam int PERIOD_W   = 16;

    typedef struct packed {
        logic [VOL_W-1:0]    vol;
        logic [PERIOD_W-1:0] period;
    } voice_cfg_t;

    function automatic voice_cfg_t unpack_word(input logic [PERIOD_W-1:0] w);
        voice_cfg_t c;
`ifdef PWM_VOLUME_EN
        c.vol    = w[15:12];
        c.period = {4'b0, w[11:0]};
`else
        c.vol    = 4'hF;
        c.period = w;
`endif
        return c;
    endfunction
endpackage

// File: rtl/pwm_voice.sv
// One square-wave voice: toggles every P ticks, muted when P is zero.
// Bit updates at the clock edge of a tick; a new word applies on the first tick after it changes.
module pwm_voice
    import synth_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_i,
    input  logic [PERIOD_W-1:0] word_i,
    output logic                voice_o,
    output logic [VOL_W-1:0]    vol_o
);
    voice_cfg_t          cfg;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                bit_q, bit_d;

    always_comb begin
        cfg   = unpack_word(word_i);
        cnt_d = cnt_q;
        bit_d = bit_q;
        if (tick_i) begin
            if (cfg.period == '0) begin
                cnt_d = '0;
                bit_d = 1'b0;
            // >= rather than == so a lowered period wraps at once instead of running to 65535
            end else if (cnt_q >= cfg.period - PERIOD_W'(1)) begin
                cnt_d = '0;
                bit_d = ~bit_q;
            end else begin
                cnt_d = cnt_q + PERIOD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            bit_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            bit_q <= bit_d;
        end
    end

    assign voice_o = bit_q;
    assign vol_o   = cfg.vol;
endmodule

// File: rtl/pwm_voice_synth.sv
// Eight-voice square-wave mixer driving a 1-bit PWM output (PWM_VOLUME_EN adds per-voice volume).
// mix_level is latched as each frame begins; pwm_out follows the carrier compare one cycle later.
module pwm_voice_synth
    import synth_pkg::*;
#(
    parameter int PRESCALE    = 50,
    parameter int CARRIER_TOP = 120
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      pwm_reg0,
    input  logic [15:0]      pwm_reg1,
    input  logic [15:0]      pwm_reg2,
    input  logic [15:0]      pwm_reg3,
    input  logic [15:0]      pwm_reg4,
    input  logic [15:0]      pwm_reg5,
    input  logic [15:0]      pwm_reg6,
    input  logic [15:0]      pwm_reg7,
    output logic             pwm_out,
    output logic [MIX_W-1:0] mix_level,
    output logic             frame_strobe
);
    logic [PERIOD_W-1:0]   word [NUM_VOICES];
    logic [NUM_VOICES-1:0] voice_bit;
    logic [VOL_W-1:0]      voice_vol [NUM_VOICES];
    logic [15:0]           presc_q, presc_d;
    logic                  tick;
    logic [MIX_W-1:0]      carrier_q, carrier_d;
    logic                  frame_end;
    logic [MIX_W-1:0]      mix;
    logic [MIX_W-1:0]      mix_level_q, mix_level_d;
    logic                  pwm_q, strobe_q;

    assign word[0] = pwm_reg0;
    assign word[1] = pwm_reg1;
    assign word[2] = pwm_reg2;
    assign word[3] = pwm_reg3;
    assign word[4] = pwm_reg4;
    assign word[5] = pwm_reg5;
    assign word[6] = pwm_reg6;
    assign word[7] = pwm_reg7;

    assign tick    = (presc_q == 16'(PRESCALE - 1));
    assign presc_d = tick ? '0 : presc_q + 16'd1;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
        pwm_voice u_voice (
            .clk     (clk),
            .rst     (rst),
            .tick_i  (tick),
            .word_i  (word[g]),
            .voice_o (voice_bit[g]),
            .vol_o   (voice_vol[g])
        );
    end

    always_comb begin
        mix = '0;
        for (int n = 0; n < NUM_VOICES; n++) begin
            if (voice_bit[n]) mix = mix + MIX_W'(voice_vol[n]);
        end
    end

    // The latch happens on the wrap edge so the new level is valid while carrier reads 0.
    assign frame_end   = (carrier_q == MIX_W'(CARRIER_TOP - 1));
    assign carrier_d   = frame_end ? '0 : carrier_q + MIX_W'(1);
    assign mix_level_d = frame_end ? mix : mix_level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            carrier_q   <= '0;
            mix_level_q <= '0;
            pwm_q       <= 1'b0;
            strobe_q    <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            carrier_q   <= carrier_d;
            mix_level_q <= mix_level_d;
            pwm_q       <= (carrier_q < mix_level_q);
            strobe_q    <= frame_end;
        end
    end

    assign pwm_out      = pwm_q;
    assign mix_level    = mix_level_q;
    assign frame_strobe = strobe_q;
endmodule
